stb_fifo_fwd: RTL
=================

# stb_fifo_fwd

Parametrised store buffer between the LSU/MMU and the data cache. It queues committed stores in order, drains them to the DCache over a req/ack handshake, and supports simultaneous push and pop. It also provides combinational store-to-load forwarding from the youngest matching buffered store. It generalises the fixed 8-bit address, 16-bit data, 4-entry store buffer in address width, data width and depth, and replaces its implicit write-priority read path.

## Interface
- ADDR_W, 8, address width
- DATA_W, 16, data width; multiple of 8
- DEPTH, 4, entry count; power of 2, ≥2
- BE_W, DATA_W/8, byte-select width (derived, not overridable)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- lsummu2stb_req  in  1  store valid
- lsummu2stb_addr  in  ADDR_W  store address
- lsummu2stb_wdata  in  DATA_W  store data
- lsummu2stb_sel_byte  in  BE_W  store byte enables
- stb2lsummu_ack  out  1  store accepted; equals !stb_full
- lsummu2stb_ld_addr  in  ADDR_W  load lookup address
- stb2lsummu_hit  out  1  forwarding hit
- stb2lsummu_rdata  out  DATA_W  forwarded data
- stb2lsummu_sel_byte  out  BE_W  byte enables of forwarded entry
- stb2dcache_req  out  1  head entry valid; equals !stb_empty
- stb2dcache_addr  out  ADDR_W  head address
- stb2dcache_wdata  out  DATA_W  head data
- stb2dcache_sel_byte  out  BE_W  head byte enables
- dcache2stb_ack  in  1  DCache consumed head
- stb_count  out  $clog2(DEPTH)+1  occupied entries
- stb_empty  out  1  stb_count == 0
- stb_full  out  1  stb_count == DEPTH

## Operation
- Storage: DEPTH entries {addr, wdata, sel_byte, valid}; wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push: occurs when lsummu2stb_req && stb2lsummu_ack. The entry is written at wr_ptr, its valid bit is set, and wr_ptr increments.
- Pop: occurs when stb2dcache_req && dcache2stb_ack. The valid bit at rd_ptr is cleared and rd_ptr increments.
- Count: incremented by push only, decremented by pop only, unchanged when both or neither occur. It never exceeds DEPTH and never underflows.
- Full: ack is 0 even if a pop occurs in the same cycle. No full-bypass.
- Empty: req is 0, and the drain outputs addr, wdata and sel_byte are driven to 0. An ack received while empty is ignored.
- Drain outputs: driven combinationally from the entry at rd_ptr. They are stable while req=1 and ack=0.
- Forwarding: an entry matches when it is valid and its addr equals lsummu2stb_ld_addr (full-width compare).
  - With one or more matches, hit=1, and rdata/sel_byte come from the youngest match, i.e. the one nearest wr_ptr-1 walking backward.
  - With no match, hit=0 and rdata/sel_byte are 0.
  - The entry being pushed in the current cycle is not visible to forwarding.
  - The entry being popped in the current cycle is still visible.
- Byte merging with cache data is the LSU's job. This block returns the raw entry plus its sel_byte.

## Timing
- Reset (asynchronous, while rst_n=0):
  - ptrs=0, count=0, all valid bits=0.
  - Outputs: ack=1, req=0, stb_empty=1, stb_full=0, hit=0, all data outputs 0.
  - Entry payloads need no reset.
- Reset mid-operation: all buffered stores are discarded immediately. Pending DCache requests drop in the same cycle as rst_n falls.
- Push latency: data is visible on the drain port in the next cycle if the buffer was empty (one-cycle push-to-req). It is visible to forwarding in the next cycle.
- Pop: takes effect at the clock edge. The next entry appears on the drain port in the following cycle.
- ack, req, hit and all data outputs are combinational from registered state plus lsummu2stb_ld_addr. There is no combinational path from lsummu2stb_req or dcache2stb_ack to any output.
- Throughput: one push and one pop per cycle sustained when not full and not empty.

## Test plan
- Reset, then 4 pushes (addr 0x10..0x13, wdata 0xA000+i, sel 2'b11), with DEPTH=4 and DATA_W=16 → after the 4th edge, stb_full=1, ack=0, count=4. A 5th push is ignored.
- Full buffer; hold dcache ack=1 for 4 cycles → drain order is 0x10,0x11,0x12,0x13 with matching data. The buffer ends with stb_empty=1, req=0 and drain outputs 0.
- Push 0x20/0x1111, push 0x20/0x2222, push 0x30/0x3333; ld_addr=0x20 → hit=1, rdata=0x2222. With ld_addr=0x40 → hit=0, rdata=0.
- Count=2, with simultaneous push and pop each cycle for 10 cycles → count stays 2, pointers wrap at least twice, FIFO order is preserved, and nothing is lost.
- Count=4 (full), push and pop in the same cycle → pop accepted, push rejected (ack=0), count=3.
- 3 entries buffered, rst_n asserted asynchronously mid-cycle → req, hit, count and stb_full go to 0 before the next clock edge. After release, the buffer behaves as empty.

Source files
------------

// File: rtl/stb_fifo_fwd.sv
// In-order store buffer with DCache drain port and youngest-match store-to-load forwarding.
// Drain and forwarding outputs depend only on registered state and the load lookup address.
module stb_fifo_fwd #(
  parameter  int ADDR_W = 8,
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 4,
  localparam int BE_W   = DATA_W / 8,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lsummu2stb_req,
  input  logic [ADDR_W-1:0] lsummu2stb_addr,
  input  logic [DATA_W-1:0] lsummu2stb_wdata,
  input  logic [BE_W-1:0]   lsummu2stb_sel_byte,
  output logic              stb2lsummu_ack,
  input  logic [ADDR_W-1:0] lsummu2stb_ld_addr,
  output logic              stb2lsummu_hit,
  output logic [DATA_W-1:0] stb2lsummu_rdata,
  output logic [BE_W-1:0]   stb2lsummu_sel_byte,
  output logic              stb2dcache_req,
  output logic [ADDR_W-1:0] stb2dcache_addr,
  output logic [DATA_W-1:0] stb2dcache_wdata,
  output logic [BE_W-1:0]   stb2dcache_sel_byte,
  input  logic              dcache2stb_ack,
  output logic [CNT_W-1:0]  stb_count,
  output logic              stb_empty,
  output logic              stb_full
);

  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [DATA_W-1:0] wdata_q [DEPTH];
  logic [BE_W-1:0]   sel_q   [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;

  assign stb_empty      = (count_q == '0);
  assign stb_full       = (count_q == CNT_W'(DEPTH));
  assign stb_count      = count_q;
  assign stb2lsummu_ack = !stb_full;
  assign stb2dcache_req = !stb_empty;

  // Accept/drain decisions use only registered status, so a pop never frees a slot for a same-cycle push.
  assign push = lsummu2stb_req && !stb_full;
  assign pop  = dcache2stb_ack && !stb_empty;

  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload is qualified by valid_q everywhere it is read, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q]  <= lsummu2stb_addr;
      wdata_q[wr_ptr_q] <= lsummu2stb_wdata;
      sel_q[wr_ptr_q]   <= lsummu2stb_sel_byte;
    end
  end

  always_comb begin
    stb2dcache_addr     = '0;
    stb2dcache_wdata    = '0;
    stb2dcache_sel_byte = '0;
    if (!stb_empty) begin
      stb2dcache_addr     = addr_q[rd_ptr_q];
      stb2dcache_wdata    = wdata_q[rd_ptr_q];
      stb2dcache_sel_byte = sel_q[rd_ptr_q];
    end
  end

  // Walk oldest-to-youngest starting at wr_ptr; later matches overwrite, so the youngest wins.
  always_comb begin : fwd_search
    logic [PTR_W-1:0] idx;
    stb2lsummu_hit      = 1'b0;
    stb2lsummu_rdata    = '0;
    stb2lsummu_sel_byte = '0;
    idx                 = wr_ptr_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_q[idx] && (addr_q[idx] == lsummu2stb_ld_addr)) begin
        stb2lsummu_hit      = 1'b1;
        stb2lsummu_rdata    = wdata_q[idx];
        stb2lsummu_sel_byte = sel_q[idx];
      end
      idx = idx + PTR_W'(1);
    end
  end

endmodule
